// File: rtl/chipper_pkg.sv
// ---------------------------------------------------------------------------
// chipper_pkg
// Shared definitions for the chipper router local-PE interface:
//   - flit width and field bit positions ([31:30] X, [29:28] Y, [27:26] Z,
//     [25] golden, [24:0] payload)
//   - NULL_FLIT, the all-zero empty-link code
//   - small helpers for null detection and golden promotion
// No ports (package).
// ---------------------------------------------------------------------------
package chipper_pkg;

    localparam int FLIT_W     = 32;
    localparam int X_HI       = 31;
    localparam int X_LO       = 30;
    localparam int Y_HI       = 29;
    localparam int Y_LO       = 28;
    localparam int Z_HI       = 27;
    localparam int Z_LO       = 26;
    localparam int GOLDEN_BIT = 25;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t NULL_FLIT = '0;

    function automatic logic is_null(input flit_t f);
        return (f == NULL_FLIT);
    endfunction

    // Golden marking makes the router arbiters favour this flit.
    function automatic flit_t promote(input flit_t f);
        flit_t r;
        r             = f;
        r[GOLDEN_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
// Synchronous flit FIFO with asynchronous active-low reset. The head entry is
// presented continuously on `head` (show-ahead); `pop` only advances it.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   push, din           write request and data (ignored when full)
//   pop                 read advance (ignored when empty)
//   head                current head entry (undefined content when empty)
//   full, empty, count  occupancy status, all from registered state
// ---------------------------------------------------------------------------
module flit_fifo
    import chipper_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  flit_t                    din,
    input  logic                     pop,
    output flit_t                    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    flit_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pe_inject_ctrl.sv
// ---------------------------------------------------------------------------
// pe_inject_ctrl
// Local-PE network interface for one chipper router node. PE flits are
// queued in a flit_fifo and offered to the router via inject_flit /
// inject_request, popped on inject_grant. A head flit denied for
// STARVE_LIMIT consecutive cycles is shown to the router as golden.
// Ejected flits from PEOUT are registered into a one-cycle strobe.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   pe_flit_in, pe_valid, pe_ready  PE push interface (pe_ready = !full)
//   inject_flit, inject_request     to router PEIN
//   inject_grant                    from router, same cycle as request
//   eject_flit_in                   router PEOUT (zero = no flit)
//   eject_valid, eject_data         registered eject to PE
//   fifo_count                      FIFO occupancy
//   starved                         head flit currently promoted
// Optional (macro PE_INJECT_STATS_EN): inj_count, starve_events, drop_count,
// 16-bit wrapping statistics counters.
// ---------------------------------------------------------------------------
module pe_inject_ctrl
    import chipper_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FLIT_W-1:0]       pe_flit_in,
    input  logic                    pe_valid,
    output logic                    pe_ready,
    output logic [FLIT_W-1:0]       inject_flit,
    output logic                    inject_request,
    input  logic                    inject_grant,
    input  logic [FLIT_W-1:0]       eject_flit_in,
    output logic                    eject_valid,
    output logic [FLIT_W-1:0]       eject_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    starved
`ifdef PE_INJECT_STATS_EN
    ,
    output logic [15:0]             inj_count,
    output logic [15:0]             starve_events,
    output logic [15:0]             drop_count
`endif
);

    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);

    flit_t             head;
    logic              full;
    logic              empty;
    logic              accept;
    logic              store;
    logic              drop;
    logic              pop;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              eject_valid_q, eject_valid_d;
    flit_t             eject_data_q, eject_data_d;

    // Zero flits are accepted from the PE but never stored: zero is the
    // empty-link code and must not reach the router as a real flit.
    assign accept = pe_valid && !full;
    assign store  = accept && !is_null(pe_flit_in);
    assign drop   = accept && is_null(pe_flit_in);
    assign pop    = !empty && inject_grant;

    flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store),
        .din   (pe_flit_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // When the FIFO is non-empty and no pop happens, the grant was low, so
    // this is a denied request cycle; saturate at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        eject_valid_d = !is_null(eject_flit_in);
        eject_data_d  = eject_valid_d ? eject_flit_in : eject_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q  <= '0;
            eject_valid_q <= 1'b0;
            eject_data_q  <= NULL_FLIT;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            eject_valid_q <= eject_valid_d;
            eject_data_q  <= eject_data_d;
        end
    end

    assign starved        = (starve_cnt_q == STARVE_C);
    assign pe_ready       = !full;
    assign inject_request = !empty;
    // Promotion only alters the presented copy; the stored head is untouched.
    assign inject_flit    = empty   ? NULL_FLIT :
                            starved ? promote(head) : head;
    assign eject_valid    = eject_valid_q;
    assign eject_data     = eject_data_q;

`ifdef PE_INJECT_STATS_EN
    logic [15:0] inj_count_q, inj_count_d;
    logic [15:0] starve_events_q, starve_events_d;
    logic [15:0] drop_count_q, drop_count_d;

    // A starvation event is counted on the edge that makes starved rise.
    always_comb begin
        inj_count_d     = inj_count_q + 16'(pop);
        starve_events_d = starve_events_q
                          + 16'((starve_cnt_d == STARVE_C) && !starved);
        drop_count_d    = drop_count_q + 16'(drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_count_q     <= '0;
            starve_events_q <= '0;
            drop_count_q    <= '0;
        end else begin
            inj_count_q     <= inj_count_d;
            starve_events_q <= starve_events_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign inj_count     = inj_count_q;
    assign starve_events = starve_events_q;
    assign drop_count    = drop_count_q;
`endif

endmodule

// File: tb/tb_pe_inject_ctrl.sv
// Self-checking bench for pe_inject_ctrl. A queue-based model of the
// injection buffer and the starvation/eject rules supplies expected values.
module tb_pe_inject_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 16;
    localparam logic [31:0] GOLD = 32'h0200_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pe_flit_in;
    logic        pe_valid;
    logic        pe_ready;
    logic [31:0] inject_flit;
    logic        inject_request;
    logic        inject_grant;
    logic [31:0] eject_flit_in;
    logic        eject_valid;
    logic [31:0] eject_data;
    logic [2:0]  fifo_count;
    logic        starved;
`ifdef PE_INJECT_STATS_EN
    logic [15:0] inj_count;
    logic [15:0] starve_events;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] mq[$];
    int          mstarve;
    logic        mev;
    logic [31:0] med;
    int          m_inj, m_sev, m_drop;

    pe_inject_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pe_flit_in     (pe_flit_in),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .inject_flit    (inject_flit),
        .inject_request (inject_request),
        .inject_grant   (inject_grant),
        .eject_flit_in  (eject_flit_in),
        .eject_valid    (eject_valid),
        .eject_data     (eject_data),
        .fifo_count     (fifo_count),
        .starved        (starved)
`ifdef PE_INJECT_STATS_EN
        ,
        .inj_count      (inj_count),
        .starve_events  (starve_events),
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_flit();
        if (mq.size() == 0) return 32'h0;
        if (mstarve == LIMIT) return mq[0] | GOLD;
        return mq[0];
    endfunction

    task automatic model_reset();
        mq.delete();
        mstarve = 0;
        mev     = 1'b0;
        med     = 32'h0;
        m_inj   = 0;
        m_sev   = 0;
        m_drop  = 0;
    endtask

    // One clock edge: advance the model with the inputs in force, then
    // settle to 1 time unit past the edge before anything is sampled.
    task automatic tick();
        bit do_pop;
        bit do_push;
        bit was_starved;
        @(posedge clk);
        do_pop      = (mq.size() > 0) && inject_grant;
        do_push     = pe_valid && (mq.size() < DEPTH);
        was_starved = (mstarve == LIMIT);
        if (mq.size() == 0 || do_pop) mstarve = 0;
        else if (mstarve < LIMIT)     mstarve = mstarve + 1;
        if (!was_starved && mstarve == LIMIT) m_sev = m_sev + 1;
        if (do_pop) begin
            void'(mq.pop_front());
            m_inj = m_inj + 1;
        end
        if (do_push) begin
            if (pe_flit_in != 32'h0) mq.push_back(pe_flit_in);
            else                     m_drop = m_drop + 1;
        end
        mev = (eject_flit_in != 32'h0);
        if (mev) med = eject_flit_in;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", inject_request); end
        checks++; if (inject_flit !== 32'h0) begin errors++; $display("FAIL reset_flit got %h want 0", inject_flit); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", pe_ready); end
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL reset_starved got %b want 0", starved); end
        checks++; if (eject_valid !== 1'b0) begin errors++; $display("FAIL reset_ev got %b want 0", eject_valid); end
        checks++; if (eject_data !== 32'h0) begin errors++; $display("FAIL reset_ed got %h want 0", eject_data); end
`ifdef PE_INJECT_STATS_EN
        checks++; if (inj_count !== 16'h0 || starve_events !== 16'h0 || drop_count !== 16'h0) begin
            errors++; $display("FAIL reset_stats got %h %h %h want 0", inj_count, starve_events, drop_count);
        end
`endif
    endtask

    task automatic test_basic_inject();
        pe_valid = 1'b1; pe_flit_in = 32'h4C00_0001; inject_grant = 1'b1;
        tick();
        pe_valid = 1'b0;
        checks++; if (inject_request !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", inject_request); end
        checks++; if (inject_flit !== 32'h4C00_0001) begin errors++; $display("FAIL basic_flit got %h want 4c000001", inject_flit); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", fifo_count); end
        tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", fifo_count); end
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL basic_req0 got %b want 0", inject_request); end
        inject_grant = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] f5;
        logic [31:0] f6;
        inject_grant = 1'b0;
        pe_valid     = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pe_flit_in = $urandom | 32'h1;
            tick();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", fifo_count); end
        checks++; if (pe_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", pe_ready); end
        f5 = 32'hA5A5_0005; pe_flit_in = f5;
        tick();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", fifo_count); end
        checks++; if (inject_flit !== exp_flit()) begin errors++; $display("FAIL full_head got %h want %h", inject_flit, exp_flit()); end
        // grant while full and PE still pushing: no bypass, so count drops
        f6 = 32'h5A5A_0006; pe_flit_in = f6; inject_grant = 1'b1;
        tick();
        inject_grant = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", fifo_count); end
        tick();
        pe_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill_count got %0d want 4", fifo_count); end
        inject_grant = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (inject_flit !== exp_flit()) begin errors++; $display("FAIL full_drain%0d got %h want %h", i, inject_flit, exp_flit()); end
            if (i == DEPTH - 1) begin
                checks++; if (inject_flit !== f6) begin errors++; $display("FAIL full_tail got %h want %h", inject_flit, f6); end
            end
            tick();
        end
        inject_grant = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", fifo_count); end
    endtask

    task automatic test_starve();
        logic [31:0] f;
        f = ($urandom & ~GOLD) | 32'h1;
        inject_grant = 1'b0; pe_valid = 1'b1; pe_flit_in = f;
        tick();
        pe_valid = 1'b0;
        checks++; if (inject_flit !== f) begin errors++; $display("FAIL starve_plain got %h want %h", inject_flit, f); end
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            if (i < LIMIT) begin
                checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_early%0d got %b want 0", i, starved); end
            end else begin
                checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_rise got %b want 1", starved); end
                checks++; if (inject_flit !== (f | GOLD)) begin errors++; $display("FAIL starve_gold got %h want %h", inject_flit, f | GOLD); end
            end
        end
        tick();
        checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_hold got %b want 1", starved); end
        inject_grant = 1'b1;
        tick();
        inject_grant = 1'b0;
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_clear got %b want 0", starved); end
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL starve_popped got %b want 0", inject_request); end
`ifdef PE_INJECT_STATS_EN
        checks++; if (starve_events !== 16'(m_sev)) begin errors++; $display("FAIL starve_events got %0d want %0d", starve_events, m_sev); end
        checks++; if (inj_count !== 16'(m_inj)) begin errors++; $display("FAIL inj_count got %0d want %0d", inj_count, m_inj); end
`endif
    endtask

    task automatic test_drop_zero();
        pe_valid = 1'b1; pe_flit_in = 32'h0;
        tick();
        pe_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL drop_count_fifo got %0d want 0", fifo_count); end
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL drop_req got %b want 0", inject_request); end
`ifdef PE_INJECT_STATS_EN
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_stat got %0d want 1", drop_count); end
`endif
    endtask

    task automatic test_eject();
        eject_flit_in = 32'h8123_4567;
        tick();
        eject_flit_in = 32'h0;
        checks++; if (eject_valid !== 1'b1) begin errors++; $display("FAIL eject_v1 got %b want 1", eject_valid); end
        checks++; if (eject_data !== 32'h8123_4567) begin errors++; $display("FAIL eject_d1 got %h want 81234567", eject_data); end
        tick();
        checks++; if (eject_valid !== 1'b0) begin errors++; $display("FAIL eject_v0 got %b want 0", eject_valid); end
        checks++; if (eject_data !== 32'h8123_4567) begin errors++; $display("FAIL eject_hold got %h want 81234567", eject_data); end
        tick();
        checks++; if (eject_data !== 32'h8123_4567) begin errors++; $display("FAIL eject_hold2 got %h want 81234567", eject_data); end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 80; c++) begin
                pe_valid      = ($urandom_range(0, 3) != 0);
                pe_flit_in    = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
                inject_grant  = ($urandom_range(0, 9) < blk);
                eject_flit_in = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
                tick();
                checks++; if (fifo_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count got %0d want %0d", fifo_count, mq.size()); end
                checks++; if (inject_request !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_req got %b want %b", inject_request, mq.size() != 0); end
                checks++; if (inject_flit !== exp_flit()) begin errors++; $display("FAIL rnd_flit got %h want %h", inject_flit, exp_flit()); end
                checks++; if (pe_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready got %b want %b", pe_ready, mq.size() < DEPTH); end
                checks++; if (starved !== (mstarve == LIMIT)) begin errors++; $display("FAIL rnd_starved got %b want %b", starved, mstarve == LIMIT); end
                checks++; if (eject_valid !== mev) begin errors++; $display("FAIL rnd_ev got %b want %b", eject_valid, mev); end
                checks++; if (eject_data !== med) begin errors++; $display("FAIL rnd_ed got %h want %h", eject_data, med); end
`ifdef PE_INJECT_STATS_EN
                checks++; if (inj_count !== 16'(m_inj) || starve_events !== 16'(m_sev) || drop_count !== 16'(m_drop)) begin
                    errors++; $display("FAIL rnd_stats got %0d %0d %0d want %0d %0d %0d", inj_count, starve_events, drop_count, m_inj, m_sev, m_drop);
                end
`endif
            end
        end
        pe_valid = 1'b0; inject_grant = 1'b0; eject_flit_in = 32'h0;
    endtask

    task automatic test_reset_mid();
        inject_grant = 1'b0; pe_valid = 1'b1;
        eject_flit_in = 32'hDEAD_BEEF;
        while (mq.size() < 3) begin
            pe_flit_in = $urandom | 32'h1;
            tick();
            eject_flit_in = 32'h0;
        end
        pe_valid = 1'b0;
        tick();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", fifo_count); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", inject_request); end
        checks++; if (inject_flit !== 32'h0) begin errors++; $display("FAIL mid_flit got %h want 0", inject_flit); end
        checks++; if (pe_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", pe_ready); end
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL mid_starved got %b want 0", starved); end
        checks++; if (eject_data !== 32'h0) begin errors++; $display("FAIL mid_ed got %h want 0", eject_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_post_count got %0d want 0", fifo_count); end
        checks++; if (inject_request !== 1'b0) begin errors++; $display("FAIL mid_post_req got %b want 0", inject_request); end
    endtask

    initial begin
        rst_n         = 1'b0;
        pe_valid      = 1'b0;
        pe_flit_in    = 32'h0;
        inject_grant  = 1'b0;
        eject_flit_in = 32'h0;
        model_reset();
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        test_basic_inject();
        test_full();
        test_starve();
        test_drop_zero();
        test_eject();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
